// File: rtl/seq_detector_param_if.sv
// Bundle of serial-input, control and result signals for seq_detector_param.
// The master drives the stream and controls; the slave returns the results.
interface seq_detector_param_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
);
  logic             in;
  logic             in_valid;
  logic [PAT_W-1:0] pattern;
  logic             load;
  logic             overlap;
  logic             count_clr;
  logic             detector;
  logic [CNT_W-1:0] match_count;

  modport master (
    output in, in_valid, pattern, load, overlap, count_clr,
    input  detector, match_count
  );

  modport slave (
    input  in, in_valid, pattern, load, overlap, count_clr,
    output detector, match_count
  );
endinterface

// File: rtl/seq_detector_param.sv
// Serial pattern detector with a loadable PAT_W-bit target, overlapping or
// non-overlapping detection, a one-cycle match pulse and a saturating counter.
module seq_detector_param #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
) (
  input logic              clk,
  input logic              nrst,
  seq_detector_param_if.slave bus
);
  localparam int FW = $clog2(PAT_W + 1);
  localparam logic [FW-1:0] FILL_FULL = FW'(PAT_W);

  logic [PAT_W-1:0] pat_reg;
  // Only the newest PAT_W-1 bits are kept; with the incoming bit they form the window.
  logic [PAT_W-2:0] hist_reg;
  logic [FW-1:0]    fill_reg;
  logic             detector_reg;
  logic [CNT_W-1:0] count_reg;

  logic [PAT_W-1:0] hist_next;
  logic [FW-1:0]    fill_next;
  logic             match;

  assign hist_next = {hist_reg, bus.in};
  assign fill_next = (fill_reg == FILL_FULL) ? fill_reg : fill_reg + FW'(1);
  assign match     = bus.in_valid && !bus.load && (hist_next == pat_reg) &&
                     (fill_next == FILL_FULL);

  always_ff @(posedge clk) begin
    if (!nrst) begin
      pat_reg      <= '1;
      hist_reg     <= '0;
      fill_reg     <= '0;
      detector_reg <= 1'b0;
      count_reg    <= '0;
    end else begin
      detector_reg <= 1'b0;
      if (bus.load) begin
        pat_reg  <= bus.pattern;
        fill_reg <= '0;
      end else if (bus.in_valid) begin
        hist_reg <= hist_next[PAT_W-2:0];
        if (match) begin
          detector_reg <= 1'b1;
          // Non-overlapping mode forces a full fresh window before the next match.
          fill_reg     <= bus.overlap ? FILL_FULL : '0;
          if (count_reg != '1) begin
            count_reg <= count_reg + CNT_W'(1);
          end
        end else begin
          fill_reg <= fill_next;
        end
      end
      if (bus.count_clr) begin
        count_reg <= '0;
      end
    end
  end

  assign bus.detector    = detector_reg;
  assign bus.match_count = count_reg;
endmodule
